axis_udp_payload_extractor: RTL and testbench

Downstream stage of `axis_udp_filter`. Consumes the filtered 64-bit AXI-Stream of Ethernet/IPv4/UDP frames and strips the 42-byte Ethernet + IPv4 (IHL = 5) + UDP header. It emits only the UDP payload, re-aligned to byte 0 and trimmed to the UDP length field, so Ethernet padding is removed. UDP source port, destination port and payload length are presented as sideband for the payload consumer.

---
 rtl/axis_udp_payload_extractor.sv | 208 ++++++++++++++++++++
 tb/tb_axis_udp_payload_extractor.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_udp_payload_extractor.sv
// Strips Ethernet/IPv4/UDP headers from a 64-bit AXI-Stream and emits the
// UDP payload realigned to byte 0, trimmed to the UDP length.
module axis_udp_payload_extractor #(
    parameter  int MAX_FRAME_SIZE  = 1518,
    localparam int AXIS_DATA_WIDTH = 64
) (
    input  logic                         axis_clk,
    input  logic                         axis_s_rst,
    input  logic                         s_axis_tvalid,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic                         m_axis_tvalid,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic [15:0]                  udp_src_port,
    output logic [15:0]                  udp_dst_port,
    output logic [15:0]                  payload_len,
    output logic                         err_bad_hdr,
    output logic                         err_truncated
);
    localparam int BEAT_W = $clog2(MAX_FRAME_SIZE / 8 + 2);

    localparam logic [1:0] S_HDR     = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_FLUSH   = 2'd2;
    localparam logic [1:0] S_DROP    = 2'd3;

    logic [1:0]        r_state;
    logic [BEAT_W-1:0] r_beat;
    logic [15:0]       r_rem;
    logic [47:0]       r_carry;
    logic [2:0]        r_cc;
    logic              r_m_valid;
    logic [63:0]       r_m_data;
    logic [7:0]        r_m_strb;
    logic              r_m_last;
    logic [15:0]       r_src;
    logic [15:0]       r_dst;
    logic [15:0]       r_len;
    logic              r_err_bad;
    logic              r_err_trunc;

    logic        w_out_rdy;
    logic        w_tready;
    logic        w_acc;
    logic [3:0]  w_n;
    logic [2:0]  w_nhi;
    logic [3:0]  w_lo2;
    logic [3:0]  w_avail;
    logic [3:0]  w_kpay;
    logic [3:0]  w_kfl;
    logic [15:0] w_ulen;
    logic [3:0]  w_ihl;
    logic        w_b5;

    function automatic logic [7:0] f_mask(input logic [3:0] k);
        return 8'hFF >> (4'd8 - k);
    endfunction

    assign w_out_rdy = !r_m_valid || m_axis_tready;
    assign w_b5      = (r_beat == BEAT_W'(5));
    assign w_n       = 4'($countones(s_axis_tstrb));
    assign w_nhi     = (w_n > 4'd2) ? 3'(w_n - 4'd2) : 3'd0;
    assign w_lo2     = (w_n > 4'd2) ? 4'd2 : w_n;
    assign w_avail   = {1'b0, r_cc} + w_lo2;
    assign w_kpay    = (r_rem < {12'd0, w_avail}) ? r_rem[3:0] : w_avail;
    assign w_kfl     = (r_rem < {13'd0, r_cc}) ? r_rem[3:0] : {1'b0, r_cc};
    assign w_ulen    = {s_axis_tdata[55:48], s_axis_tdata[63:56]};
    assign w_ihl     = s_axis_tdata[51:48];

    // Header beats never stall; only beats that can emit follow the output.
    always_comb begin
        w_tready = 1'b0;
        case (r_state)
            S_HDR:     w_tready = w_b5 ? w_out_rdy : 1'b1;
            S_PAYLOAD: w_tready = w_out_rdy;
            S_FLUSH:   w_tready = 1'b0;
            S_DROP:    w_tready = 1'b1;
            default:   w_tready = 1'b0;
        endcase
    end

    assign s_axis_tready = w_tready && !axis_s_rst;
    assign w_acc         = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge axis_clk) begin
        if (axis_s_rst) begin
            r_state     <= S_HDR;
            r_beat      <= '0;
            r_rem       <= '0;
            r_carry     <= '0;
            r_cc        <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_strb    <= '0;
            r_m_last    <= 1'b0;
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_err_bad   <= 1'b0;
            r_err_trunc <= 1'b0;
        end else begin
            r_err_bad   <= 1'b0;
            r_err_trunc <= 1'b0;
            if (m_axis_tready) r_m_valid <= 1'b0;
            case (r_state)
                S_HDR: begin
                    if (w_acc && !w_b5) begin
                        if (s_axis_tlast) begin
                            r_err_bad <= 1'b1;
                            r_beat    <= '0;
                        end else if (r_beat == BEAT_W'(1) && w_ihl != 4'd5) begin
                            r_err_bad <= 1'b1;
                            r_beat    <= '0;
                            r_state   <= S_DROP;
                        end else if (r_beat == BEAT_W'(4)) begin
                            r_src <= {s_axis_tdata[23:16], s_axis_tdata[31:24]};
                            r_dst <= {s_axis_tdata[39:32], s_axis_tdata[47:40]};
                            r_len <= w_ulen - 16'd8;
                            r_rem <= w_ulen - 16'd8;
                            if (w_ulen <= 16'd8) begin
                                r_err_bad <= (w_ulen < 16'd8);
                                r_beat    <= '0;
                                r_state   <= S_DROP;
                            end else begin
                                r_beat <= r_beat + BEAT_W'(1);
                            end
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end else if (w_acc) begin
                        r_carry <= s_axis_tdata[63:16];
                        r_cc    <= w_nhi;
                        r_beat  <= '0;
                        if (r_rem <= {13'd0, w_nhi}) begin
                            r_m_valid <= 1'b1;
                            r_m_data  <= {16'd0, s_axis_tdata[63:16]};
                            r_m_strb  <= f_mask(r_rem[3:0]);
                            r_m_last  <= 1'b1;
                            r_state   <= s_axis_tlast ? S_HDR : S_DROP;
                        end else if (s_axis_tlast) begin
                            r_m_valid   <= 1'b1;
                            r_m_data    <= {16'd0, s_axis_tdata[63:16]};
                            r_m_strb    <= f_mask({1'b0, w_nhi});
                            r_m_last    <= 1'b1;
                            r_err_trunc <= 1'b1;
                            r_state     <= S_HDR;
                        end else begin
                            r_state <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_acc) begin
                        r_m_valid <= 1'b1;
                        r_m_data  <= {s_axis_tdata[15:0], r_carry};
                        r_m_strb  <= f_mask(w_kpay);
                        r_m_last  <= 1'b0;
                        r_rem     <= r_rem - {12'd0, w_kpay};
                        r_carry   <= s_axis_tdata[63:16];
                        r_cc      <= w_nhi;
                        if (r_rem == {12'd0, w_kpay}) begin
                            r_m_last <= 1'b1;
                            r_state  <= s_axis_tlast ? S_HDR : S_DROP;
                        end else if (s_axis_tlast) begin
                            if (w_nhi != 3'd0) begin
                                r_state <= S_FLUSH;
                            end else begin
                                r_m_last    <= 1'b1;
                                r_err_trunc <= 1'b1;
                                r_state     <= S_HDR;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    // Short only when the carried tail cannot cover the length.
                    if (w_out_rdy) begin
                        r_m_valid   <= 1'b1;
                        r_m_data    <= {16'd0, r_carry};
                        r_m_strb    <= f_mask(w_kfl);
                        r_m_last    <= 1'b1;
                        r_err_trunc <= (r_rem > {13'd0, r_cc});
                        r_state     <= S_HDR;
                    end
                end
                S_DROP: begin
                    if (w_acc && s_axis_tlast) r_state <= S_HDR;
                end
                default: r_state <= S_HDR;
            endcase
        end
    end

    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tstrb  = r_m_strb;
    assign m_axis_tlast  = r_m_last;
    assign udp_src_port  = r_src;
    assign udp_dst_port  = r_dst;
    assign payload_len   = r_len;
    assign err_bad_hdr   = r_err_bad;
    assign err_truncated = r_err_trunc;
endmodule

// File: tb/tb_axis_udp_payload_extractor.sv
// Directed table-driven bench for axis_udp_payload_extractor plus
// back-to-back stalled frames and a mid-payload reset sequence.
module tb_axis_udp_payload_extractor;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_tvalid;
    logic [63:0] s_tdata;
    logic [7:0]  s_tstrb;
    logic        s_tlast;
    logic        s_tready;
    logic        m_tvalid;
    logic [63:0] m_tdata;
    logic [7:0]  m_tstrb;
    logic        m_tlast;
    logic        m_tready;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] plen;
    logic        e_bad;
    logic        e_trunc;

    always #5 clk = ~clk;

    axis_udp_payload_extractor #(.MAX_FRAME_SIZE(1518)) dut (
        .axis_clk(clk),
        .axis_s_rst(rst),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tdata(s_tdata),
        .s_axis_tstrb(s_tstrb),
        .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tdata(m_tdata),
        .m_axis_tstrb(m_tstrb),
        .m_axis_tlast(m_tlast),
        .m_axis_tready(m_tready),
        .udp_src_port(src_port),
        .udp_dst_port(dst_port),
        .payload_len(plen),
        .err_bad_hdr(e_bad),
        .err_truncated(e_trunc)
    );

    typedef struct {
        int         len;
        logic [3:0] ihl;
        int         ulen;
        int         beats;
        logic [7:0] lstrb;
        int         bad;
        int         trunc;
        int         nbytes;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int n_beats = 0;
    int n_last = 0;
    int n_bad = 0;
    int n_trunc = 0;
    int stall_viol = 0;
    logic [7:0] last_strb = 8'h00;
    logic rand_rdy = 1'b0;
    logic [7:0] q_out[$];
    logic [7:0] frm[$];
    logic [7:0] exp_q[$];
    vec_t vt[13];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Output monitor: sampled mid-cycle, away from the active edge.
    logic        p_stall = 1'b0;
    logic [73:0] p_snap = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (m_tvalid && m_tready) begin
                n_beats++;
                for (int b = 0; b < 8; b++)
                    if (m_tstrb[b]) q_out.push_back(m_tdata[8*b +: 8]);
                if (m_tlast) begin
                    n_last++;
                    last_strb = m_tstrb;
                end
            end
            if (e_bad) n_bad++;
            if (e_trunc) n_trunc++;
            if (p_stall && {m_tvalid, m_tdata, m_tstrb, m_tlast} != p_snap)
                stall_viol++;
            p_stall = m_tvalid && !m_tready;
            p_snap  = {m_tvalid, m_tdata, m_tstrb, m_tlast};
        end else begin
            p_stall = 1'b0;
        end
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic build_frame(input int len, input logic [3:0] ihl,
                               input int ulen, input logic [15:0] sp,
                               input logic [15:0] dp);
        frm.delete();
        for (int i = 0; i < len; i++)
            frm.push_back(i < 42 ? 8'(i * 7 + 3) : 8'(i - 41));
        frm[14] = {4'h4, ihl};
        frm[34] = sp[15:8];
        frm[35] = sp[7:0];
        frm[36] = dp[15:8];
        frm[37] = dp[7:0];
        frm[38] = 8'(ulen >> 8);
        frm[39] = 8'(ulen);
    endtask

    task automatic send_frame(input int stop_beats);
        int nb;
        int idx;
        int t;
        logic acc;
        nb = (frm.size() + 7) / 8;
        for (int bi = 0; bi < nb && bi < stop_beats; bi++) begin
            s_tdata = '0;
            s_tstrb = '0;
            for (int b = 0; b < 8; b++) begin
                idx = bi * 8 + b;
                if (idx < frm.size()) begin
                    s_tdata[8*b +: 8] = frm[idx];
                    s_tstrb[b] = 1'b1;
                end
            end
            s_tlast  = (bi == nb - 1);
            s_tvalid = 1'b1;
            t = 0;
            acc = 1'b0;
            while (!acc && t < 2000) begin
                @(negedge clk);
                acc = s_tready;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) chk("send_timeout", 0, 1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic run_row(input int r);
        int b_beats;
        int b_last;
        int b_bad;
        int b_tr;
        int mism;
        logic [15:0] sp;
        logic [15:0] dp;
        sp = 16'hC000 + 16'(r);
        dp = 16'h0035 + 16'(r);
        q_out.delete();
        b_beats = n_beats;
        b_last  = n_last;
        b_bad   = n_bad;
        b_tr    = n_trunc;
        build_frame(vt[r].len, vt[r].ihl, vt[r].ulen, sp, dp);
        send_frame(1000);
        repeat (10) @(posedge clk);
        #1;
        chk($sformatf("row%0d_beats", r), n_beats - b_beats, vt[r].beats);
        chk($sformatf("row%0d_tlast", r), n_last - b_last, vt[r].beats > 0 ? 1 : 0);
        chk($sformatf("row%0d_bad", r), n_bad - b_bad, vt[r].bad);
        chk($sformatf("row%0d_trunc", r), n_trunc - b_tr, vt[r].trunc);
        chk($sformatf("row%0d_nbytes", r), q_out.size(), vt[r].nbytes);
        if (vt[r].beats > 0) begin
            chk($sformatf("row%0d_lstrb", r), last_strb, vt[r].lstrb);
            chk($sformatf("row%0d_src", r), src_port, sp);
            chk($sformatf("row%0d_dst", r), dst_port, dp);
            chk($sformatf("row%0d_plen", r), plen, 16'(vt[r].ulen - 8));
        end
        mism = 0;
        for (int i = 0; i < vt[r].nbytes && q_out.size() > 0; i++)
            if (q_out.pop_front() != frm[42 + i]) mism++;
        chk($sformatf("row%0d_data", r), mism, 0);
        q_out.delete();
    endtask

    initial begin
        int b_beats;
        int b_last;
        int b_bad;
        int b_tr;
        int mism;
        int t;
        vt[0]  = '{64, 4'd5, 30, 3, 8'h3F, 0, 0, 22};
        vt[1]  = '{60, 4'd5, 12, 1, 8'h0F, 0, 0, 4};
        vt[2]  = '{70, 4'd5, 100, 4, 8'h0F, 0, 1, 28};
        vt[3]  = '{64, 4'd6, 30, 0, 8'h00, 1, 0, 0};
        vt[4]  = '{64, 4'd5, 4, 0, 8'h00, 1, 0, 0};
        vt[5]  = '{64, 4'd5, 8, 0, 8'h00, 0, 0, 0};
        vt[6]  = '{64, 4'd5, 30, 3, 8'h3F, 0, 0, 22};
        vt[7]  = '{40, 4'd5, 30, 0, 8'h00, 1, 0, 0};
        vt[8]  = '{48, 4'd5, 14, 1, 8'h3F, 0, 0, 6};
        vt[9]  = '{46, 4'd5, 20, 1, 8'h0F, 0, 1, 4};
        vt[10] = '{65, 4'd5, 31, 3, 8'h7F, 0, 0, 23};
        vt[11] = '{58, 4'd5, 20, 2, 8'h0F, 0, 0, 12};
        vt[12] = '{58, 4'd5, 100, 2, 8'hFF, 0, 1, 16};

        rst = 1'b1;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_tstrb = '0;
        s_tlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_sideband", {src_port, dst_port, plen}, 0);
        chk("rst_err", {e_bad, e_trunc}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_tready", s_tready, 1);
        @(posedge clk);
        #1;

        for (int r = 0; r < 13; r++) run_row(r);

        // Back-to-back maximum frames with a randomly stalling sink.
        q_out.delete();
        exp_q.delete();
        b_beats = n_beats;
        b_last  = n_last;
        b_bad   = n_bad;
        b_tr    = n_trunc;
        rand_rdy = 1'b1;
        for (int f = 0; f < 3; f++) begin
            build_frame(1518, 4'd5, 1484, 16'h1111 * 16'(f + 1), 16'h0400 + 16'(f));
            for (int i = 0; i < 1476; i++) exp_q.push_back(frm[42 + i]);
            send_frame(1000);
        end
        t = 0;
        while (n_last < b_last + 3 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        rand_rdy = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("big_frames_done", n_last - b_last, 3);
        chk("big_beats", n_beats - b_beats, 555);
        chk("big_nbytes", q_out.size(), 3 * 1476);
        chk("big_errs", (n_bad - b_bad) + (n_trunc - b_tr), 0);
        chk("big_src", src_port, 16'h3333);
        mism = 0;
        while (q_out.size() > 0 && exp_q.size() > 0)
            if (q_out.pop_front() != exp_q.pop_front()) mism++;
        chk("big_data", mism, 0);
        chk("stall_hold", stall_viol, 0);
        q_out.delete();

        // Reset while a payload beat is pending on the output.
        build_frame(1518, 4'd5, 1484, 16'hABCD, 16'h1234);
        send_frame(8);
        chk("pre_rst_valid", m_tvalid, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_m_out", {m_tdata, m_tstrb, m_tlast}, 0);
        chk("midrst_s_tready", s_tready, 0);
        chk("midrst_sideband", {src_port, dst_port, plen}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_after_tready", s_tready, 1);
        @(posedge clk);
        #1;
        run_row(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
